// File: rtl/mod_n_counter.sv
// Loadable up/down modulo-N counter digit with cascade carry/borrow, load range
// check and a sticky wrap flag. Chain digits by feeding Cout into the next Cin.
module mod_n_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             Load,
    input  logic [WIDTH-1:0] P,
    input  logic             Enable,
    input  logic             Cin,
    input  logic             Up,
    input  logic             ClrFlag,
    output logic [WIDTH-1:0] Q,
    output logic             Cout,
    output logic             LoadErr,
    output logic             WrapFlag
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $fatal(1, "mod_n_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $fatal(1, "mod_n_counter: RESET_VAL %0d not below MODULUS %0d", RESET_VAL, MODULUS);
    end

    // Terminal values are compared explicitly, so MODULUS == 2**WIDTH needs no modulo.
    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    logic terminal;
    logic count_en;

    assign terminal = Up ? (Q == MAXV) : (Q == '0);
    assign count_en = Enable & Cin & ~Load & ~MR;
    assign Cout     = count_en & terminal;

    always_ff @(posedge CLK) begin
        if (MR) begin
            Q        <= RST_Q;
            LoadErr  <= 1'b0;
            WrapFlag <= 1'b0;
        end else begin
            LoadErr <= 1'b0;
            if (Load) begin
                if (P > MAXV)
                    LoadErr <= 1'b1;
                else
                    Q <= P;
            end else if (Enable && Cin) begin
                if (Up)
                    Q <= (Q == MAXV) ? '0 : Q + WIDTH'(1);
                else
                    Q <= (Q == '0) ? MAXV : Q - WIDTH'(1);
            end
            // A wrap on this edge beats a simultaneous clear.
            WrapFlag <= Cout | (WrapFlag & ~ClrFlag);
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed bench for mod_n_counter: single digit (mod 10), boundary digit (mod 8)
// and a two-digit decimal cascade, checked against a behavioural scoreboard.
module tb_mod_n_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // digit A: WIDTH 4, MODULUS 10
    logic       a_mr, a_load, a_en, a_cin, a_up, a_clr;
    logic [3:0] a_p, a_q;
    logic       a_cout, a_le, a_wf;
    // digit C: WIDTH 3, MODULUS 8
    logic       c_mr, c_load, c_en, c_cin, c_up, c_clr;
    logic [2:0] c_p, c_q;
    logic       c_cout, c_le, c_wf;
    // cascade: units + tens
    logic       k_mr, k_load, k_en, k_up, k_clr;
    logic [3:0] k_p, u_q, t_q;
    logic       u_cout, u_le, u_wf, t_cout, t_le, t_wf;

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_a (
        .CLK(clk), .MR(a_mr), .Load(a_load), .P(a_p), .Enable(a_en), .Cin(a_cin),
        .Up(a_up), .ClrFlag(a_clr), .Q(a_q), .Cout(a_cout), .LoadErr(a_le), .WrapFlag(a_wf));

    mod_n_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) u_c (
        .CLK(clk), .MR(c_mr), .Load(c_load), .P(c_p), .Enable(c_en), .Cin(c_cin),
        .Up(c_up), .ClrFlag(c_clr), .Q(c_q), .Cout(c_cout), .LoadErr(c_le), .WrapFlag(c_wf));

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_units (
        .CLK(clk), .MR(k_mr), .Load(k_load), .P(k_p), .Enable(k_en), .Cin(1'b1),
        .Up(k_up), .ClrFlag(k_clr), .Q(u_q), .Cout(u_cout), .LoadErr(u_le), .WrapFlag(u_wf));

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_tens (
        .CLK(clk), .MR(k_mr), .Load(k_load), .P(k_p), .Enable(k_en), .Cin(u_cout),
        .Up(k_up), .ClrFlag(k_clr), .Q(t_q), .Cout(t_cout), .LoadErr(t_le), .WrapFlag(t_wf));

    typedef struct {
        int q;
        bit le;
        bit wf;
        bit cout;
    } st_t;

    typedef struct {
        string tag;
        int    q;
        bit    le;
        bit    wf;
    } exp_t;

    exp_t sbq[$];
    st_t  ma, mc, mu, mt;
    int   nvec = 0;
    int   nmis = 0;

    // Reference behaviour: cout is for the current cycle, q/le/wf are after the edge.
    function automatic st_t model(input int md, input st_t s, input bit mr, input bit load,
                                  input int p, input bit en, input bit cin, input bit up,
                                  input bit clr);
        st_t n;
        bit  term;
        term   = up ? (s.q == md - 1) : (s.q == 0);
        n.cout = en && cin && !load && !mr && term;
        n.q    = s.q;
        n.le   = 1'b0;
        n.wf   = s.wf;
        if (mr) begin
            n.q  = 0;
            n.wf = 1'b0;
        end else begin
            if (load) begin
                if (p < md) n.q = p;
                else        n.le = 1'b1;
            end else if (en && cin) begin
                n.q = up ? (s.q + 1) % md : (s.q + md - 1) % md;
            end
            n.wf = n.cout || (s.wf && !clr);
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input logic [31:0] q, input logic le, input logic wf);
        exp_t e;
        if (sbq.size() == 0) begin
            nvec++;
            nmis++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbq.pop_front();
            chk({e.tag, ".Q"}, q, e.q);
            chk({e.tag, ".LoadErr"}, {31'b0, le}, {31'b0, e.le});
            chk({e.tag, ".WrapFlag"}, {31'b0, wf}, {31'b0, e.wf});
        end
    endtask

    task automatic step_a(input string tag, input bit mr, input bit load, input int p,
                          input bit en, input bit cin, input bit up, input bit clr);
        st_t n;
        a_mr = mr; a_load = load; a_p = p[3:0]; a_en = en; a_cin = cin; a_up = up; a_clr = clr;
        #1;
        n = model(10, ma, mr, load, p, en, cin, up, clr);
        chk({tag, ".Cout"}, {31'b0, a_cout}, {31'b0, n.cout});
        sbq.push_back('{tag, n.q, n.le, n.wf});
        ma = n;
        @(posedge clk); #1;
        pop_chk({28'b0, a_q}, a_le, a_wf);
    endtask

    task automatic step_c(input string tag, input bit mr, input bit load, input int p,
                          input bit en, input bit up, input bit clr);
        st_t n;
        c_mr = mr; c_load = load; c_p = p[2:0]; c_en = en; c_cin = 1'b1; c_up = up; c_clr = clr;
        #1;
        n = model(8, mc, mr, load, p, en, 1'b1, up, clr);
        chk({tag, ".Cout"}, {31'b0, c_cout}, {31'b0, n.cout});
        sbq.push_back('{tag, n.q, n.le, n.wf});
        mc = n;
        @(posedge clk); #1;
        pop_chk({29'b0, c_q}, c_le, c_wf);
    endtask

    task automatic step_k(input string tag, input bit mr, input bit en, input bit up);
        st_t nu, nt;
        k_mr = mr; k_load = 1'b0; k_p = 4'd0; k_en = en; k_up = up; k_clr = 1'b0;
        #1;
        nu = model(10, mu, mr, 1'b0, 0, en, 1'b1, up, 1'b0);
        nt = model(10, mt, mr, 1'b0, 0, en, nu.cout, up, 1'b0);
        chk({tag, ".units.Cout"}, {31'b0, u_cout}, {31'b0, nu.cout});
        chk({tag, ".tens.Cout"}, {31'b0, t_cout}, {31'b0, nt.cout});
        sbq.push_back('{{tag, ".units"}, nu.q, nu.le, nu.wf});
        sbq.push_back('{{tag, ".tens"}, nt.q, nt.le, nt.wf});
        mu = nu;
        mt = nt;
        @(posedge clk); #1;
        pop_chk({28'b0, u_q}, u_le, u_wf);
        pop_chk({28'b0, t_q}, t_le, t_wf);
    endtask

    initial begin
        ma = '{0, 1'b0, 1'b0, 1'b0};
        mc = ma; mu = ma; mt = ma;
        k_mr = 1'b1; k_load = 1'b0; k_p = '0; k_en = 1'b0; k_up = 1'b1; k_clr = 1'b0;
        c_mr = 1'b1; c_load = 1'b0; c_p = '0; c_en = 1'b0; c_cin = 1'b1; c_up = 1'b1; c_clr = 1'b0;

        // reset dominates load and enable
        step_a("rst0", 1, 1, 7, 1, 1, 1, 0);
        step_a("rst1", 1, 1, 7, 1, 1, 1, 0);
        // up count with wrap: 1..9,0,1,2
        for (int i = 0; i < 12; i++) step_a($sformatf("up%0d", i), 0, 0, 0, 1, 1, 1, 0);
        step_a("hold_en", 0, 0, 0, 0, 1, 1, 0);
        step_a("hold_cin", 0, 0, 0, 1, 0, 1, 0);
        // down count and direction flip
        step_a("ld2", 0, 1, 2, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step_a($sformatf("dn%0d", i), 0, 0, 0, 1, 1, 0, 0);
        step_a("flip_up", 0, 0, 0, 1, 1, 1, 0);
        // load at terminal with enable: no count, no wrap
        step_a("ld5_at9", 0, 1, 5, 1, 1, 1, 0);
        step_a("ld12_bad", 0, 1, 12, 1, 1, 1, 0);
        step_a("after_bad", 0, 0, 0, 1, 1, 1, 0);
        step_a("clr_only", 0, 0, 0, 0, 1, 1, 1);
        step_a("pre_mr", 0, 0, 0, 1, 1, 1, 0);
        step_a("mr_mid", 1, 0, 0, 1, 1, 1, 0);
        step_a("post_mr", 0, 0, 0, 1, 1, 1, 0);

        // full-range modulus: 7 -> 0, clear collides with wrap
        step_c("c_rst", 1, 0, 0, 0, 1, 0);
        step_c("c_ld7", 0, 1, 7, 1, 1, 0);
        step_c("c_wrapclr", 0, 0, 0, 1, 1, 1);
        step_c("c_clr", 0, 0, 0, 0, 1, 1);
        step_c("c_dn_wrap", 0, 0, 0, 1, 0, 0);

        // two-digit cascade 00..99 -> 00
        step_k("k_rst", 1, 1, 1);
        for (int i = 0; i < 100; i++) step_k($sformatf("k%0d", i), 0, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
- Parametrised, loadable, up/down modulo-N counter; the next generation of the team's decade counter.
- Adds width and modulus generalisation, a direction control and cascade carry in/out so digits chain into multi-digit counters.
- Adds load range checking and a sticky wrap flag.
- Sits in the counter/timer library. Used standalone or as one digit of a cascaded chain driven by a common clock.

Parameters:
- WIDTH, 4, bit width of P and Q.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; any other value is an elaboration-time fatal error.
- RESET_VAL, 0, value Q takes on reset. Must be < MODULUS, else elaboration-time fatal error.

Ports:
- CLK, input, 1, single clock; all state updates on the rising edge.
- MR, input, 1, master reset; synchronous, active-high.
- Load, input, 1, parallel load request.
- P, input, WIDTH, parallel load value.
- Enable, input, 1, local count enable.
- Cin, input, 1, cascade carry/borrow in. Tie to 1 on the least-significant digit.
- Up, input, 1, direction: 1 = count up, 0 = count down.
- ClrFlag, input, 1, clears WrapFlag.
- Q, output, WIDTH, current count.
- Cout, output, 1, cascade carry/borrow out; combinational.
- LoadErr, output, 1, one-cycle pulse when a load is rejected.
- WrapFlag, output, 1, sticky flag: a wrap occurred.

Behaviour:
- Reset, sampled on a CLK edge with MR=1:
  - Q = RESET_VAL, LoadErr = 0, WrapFlag = 0.
  - MR overrides every other input.
  - MR asserted mid-count takes effect at that edge. No partial state remains.
- Priority per edge: MR > Load > count (Enable & Cin) > hold.
- Load (Load=1, MR=0):
  - If P < MODULUS: Q <= P exactly (no increment), LoadErr <= 0.
  - If P >= MODULUS: Q holds, LoadErr <= 1 for exactly one cycle.
  - Load overrides count and ignores Enable/Cin.
  - Load never sets WrapFlag.
- Count (Load=0, Enable=1, Cin=1):
  - Up=1: Q <= (Q == MODULUS-1) ? 0 : Q+1.
  - Up=0: Q <= (Q == 0) ? MODULUS-1 : Q-1.
  - Never use a native % on the full WIDTH range; wrap is an explicit compare so that MODULUS = 2**WIDTH is also correct.
- Hold: with Enable=0 or Cin=0, Q is unchanged.
- Up may change on any cycle. It takes effect at the next counting edge; no dead cycle.
- Cout (combinational) = Enable & Cin & ~Load & ~MR & terminal, where:
  - terminal = (Q == MODULUS-1) when Up=1.
  - terminal = (Q == 0) when Up=0.
  - In a cascade, each higher digit's Cin = the lower digit's Cout. The whole chain shares CLK/MR/Up.
- WrapFlag:
  - Set on any edge where Cout=1 (the wrap occurs at that edge).
  - Cleared by ClrFlag=1 unless a wrap occurs on the same edge; set wins.
  - Cleared by MR.
- LoadErr is 0 on every cycle other than the one following a rejected load.
- Latency:
  - Q reflects load/count one edge after the inputs are sampled.
  - Cout reflects Q and the inputs in the same cycle.
- Outputs are never X after the first edge with MR=1.

Test Plan:
- Reset: MR=1 for 2 edges with Enable=1, Load=1, P=7 -> Q=0, LoadErr=0, WrapFlag=0. Release MR -> counting resumes from 0 on the next edge.
- Up-count wrap: WIDTH=4, MODULUS=10, Enable=Cin=Up=1 from Q=0 for 12 edges -> sequence 1..9,0,1,2. Cout=1 only while Q=9. WrapFlag=1 from the edge Q goes 9->0.
- Down-count and direction change: load 2, Up=0 -> Q 1,0,9,8 with Cout=1 while Q=0. Flip Up=1 at Q=8 -> next Q=9, no dead cycle.
- Load check:
  - Load=1, P=5 -> Q=5 at the next edge, not 6.
  - Load=1, P=12 -> Q unchanged, LoadErr=1 for exactly one cycle.
  - Load=1 with Enable=1 and Q=9 -> Q=P, Cout=0, WrapFlag unchanged.
- Cascade: two instances (units Cin=1, tens Cin=units.Cout), up-count from 00 for 100 edges -> tens/units go 00..99 then 00. Tens Cout=1 only at 99. Tens holds while units count 0..8.
- Boundary modulus: WIDTH=3, MODULUS=8 up from 7 -> Q=0, Cout=1 at Q=7. ClrFlag and a wrap on the same edge -> WrapFlag stays 1. ClrFlag alone -> WrapFlag=0.
